// File: rtl/fetch_unit_pkg.sv
// Shared core definitions for the fetch stage: datapath width, reset
// instruction, and the fetch FSM state encoding.
package fetch_unit_pkg;

   localparam int XLEN = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one imem read per fetch_enable pulse, fixed-latency
// data capture, architectural PC tracking with pending branch/jump redirects.
//
//  state | meaning
//  IDLE  | waiting for fetch_enable; picks redirect > pending > pc as address
//  WAIT  | read issued; counting down MEM_LATENCY until imem_rdata is valid
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                       XLEN        = fetch_unit_pkg::XLEN,
   parameter logic [XLEN-1:0]          RESET_PC    = '0,
   parameter int                       MEM_LATENCY = 1,
   parameter logic [XLEN-1:0]          NOP_INSTR   = XLEN'(fetch_unit_pkg::NOP_INSTR)
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            fetch_enable,
   output logic            fetch_done,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_en,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   output logic            fetch_err
);

   localparam logic [2:0] LAT = 3'(MEM_LATENCY);

   fetch_state_e    state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] cur_addr;
   logic            pending_valid;
   logic [XLEN-1:0] pending_pc;
   logic [2:0]      lat_cnt;
   logic [XLEN-1:0] redirect_aligned;
   logic [XLEN-1:0] sel_addr;

   assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};

   always_comb begin
      sel_addr = pc;
      if (redirect_valid)
         sel_addr = redirect_aligned;
      else if (pending_valid)
         sel_addr = pending_pc;
      sel_addr[1:0] = 2'b00;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state         <= IDLE;
         pc            <= RESET_PC;
         cur_addr      <= '0;
         pending_valid <= 1'b0;
         pending_pc    <= '0;
         lat_cnt       <= '0;
         instr         <= NOP_INSTR;
         instr_pc      <= RESET_PC;
         fetch_done    <= 1'b0;
         imem_en       <= 1'b0;
         imem_addr     <= '0;
         fetch_err     <= 1'b0;
      end else begin
         fetch_done <= 1'b0;
         case (state)
            IDLE: begin
               if (fetch_enable) begin
                  imem_addr     <= sel_addr;
                  cur_addr      <= sel_addr;
                  imem_en       <= 1'b1;
                  pending_valid <= 1'b0;
                  lat_cnt       <= LAT;
                  state         <= WAIT;
               end else if (redirect_valid) begin
                  pending_valid <= 1'b1;
                  pending_pc    <= redirect_aligned;
               end
            end
            WAIT: begin
               imem_en <= 1'b0;
               if (redirect_valid) begin
                  pending_valid <= 1'b1;
                  pending_pc    <= redirect_aligned;
               end
               // A second start while busy is a controller bug; flag it, keep going.
               if (fetch_enable)
                  fetch_err <= 1'b1;
               if (lat_cnt == 3'd0) begin
                  instr      <= imem_rdata;
                  instr_pc   <= cur_addr;
                  pc         <= cur_addr + XLEN'(4);
                  fetch_done <= 1'b1;
                  state      <= IDLE;
               end else begin
                  lat_cnt <= lat_cnt - 3'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: one instance at latency 1, one at latency 4.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rstn;
   logic        fe0, rv0, done0, en0, err0;
   logic [31:0] rp0, addr0, rdata0, instr0, ipc0;
   logic        fe1, rv1, done1, en1, err1;
   logic [31:0] rp1, addr1, rdata1, instr1, ipc1;

   int ntests = 0;
   int nfail  = 0;

   always #5 clk = ~clk;

   fetch_unit #(.MEM_LATENCY(1)) u0 (
      .clk(clk), .rstn(rstn), .fetch_enable(fe0), .fetch_done(done0),
      .redirect_valid(rv0), .redirect_pc(rp0), .imem_en(en0), .imem_addr(addr0),
      .imem_rdata(rdata0), .instr(instr0), .instr_pc(ipc0), .fetch_err(err0)
   );

   fetch_unit #(.MEM_LATENCY(4)) u1 (
      .clk(clk), .rstn(rstn), .fetch_enable(fe1), .fetch_done(done1),
      .redirect_valid(rv1), .redirect_pc(rp1), .imem_en(en1), .imem_addr(addr1),
      .imem_rdata(rdata1), .instr(instr1), .instr_pc(ipc1), .fetch_err(err1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int en_cnt, done_cnt, done_at;
      rstn = 1'b0;
      fe0 = 0; rv0 = 0; rp0 = '0; rdata0 = '0;
      fe1 = 0; rv1 = 0; rp1 = '0; rdata1 = '0;
      tick(); tick();
      check("rst_imem_en", 32'(en0), 32'd0);
      check("rst_done", 32'(done0), 32'd0);
      check("rst_instr", instr0, 32'h0000_0013);
      check("rst_instr_pc", ipc0, 32'h0);
      check("rst_err", 32'(err0), 32'd0);
      check("rst_addr", addr0, 32'h0);
      rstn = 1'b1;
      tick();

      // first fetch from reset PC
      rdata0 = 32'h0050_0093; fe0 = 1; tick(); fe0 = 0;
      check("f1_en", 32'(en0), 32'd1);
      check("f1_addr", addr0, 32'h0);
      check("f1_no_done_early", 32'(done0), 32'd0);
      tick();
      check("f1_en_drop", 32'(en0), 32'd0);
      check("f1_no_done_mid", 32'(done0), 32'd0);
      tick();
      check("f1_done", 32'(done0), 32'd1);
      check("f1_instr", instr0, 32'h0050_0093);
      check("f1_ipc", ipc0, 32'h0);

      // back-to-back start in the done cycle
      rdata0 = 32'h0010_0113; fe0 = 1; tick(); fe0 = 0;
      check("f2_addr", addr0, 32'h4);
      check("f2_done_one_pulse", 32'(done0), 32'd0);
      tick(); tick();
      check("f2_done", 32'(done0), 32'd1);
      check("f2_instr", instr0, 32'h0010_0113);
      check("f2_ipc", ipc0, 32'h4);

      // redirect together with start; low bits forced to zero
      rdata0 = 32'h1111_1111; fe0 = 1; rv0 = 1; rp0 = 32'h0000_0103; tick();
      fe0 = 0; rv0 = 0;
      check("rd_addr", addr0, 32'h100);
      tick(); tick();
      check("rd_ipc", ipc0, 32'h100);

      // two redirects during WAIT: last wins, in-flight completes as-is
      rdata0 = 32'h2222_2222; fe0 = 1; tick(); fe0 = 0;
      check("seq_addr", addr0, 32'h104);
      rv0 = 1; rp0 = 32'h200; tick();
      rp0 = 32'h300; tick(); rv0 = 0;
      check("seq_done", 32'(done0), 32'd1);
      check("seq_ipc", ipc0, 32'h104);
      check("seq_instr", instr0, 32'h2222_2222);
      fe0 = 1; tick(); fe0 = 0;
      check("pend_addr", addr0, 32'h300);
      tick(); tick();
      check("pend_ipc", ipc0, 32'h300);

      // redirect in IDLE without start is held as pending
      rv0 = 1; rp0 = 32'h400; tick(); rv0 = 0;
      check("idle_rd_no_fetch", 32'(en0), 32'd0);
      fe0 = 1; tick(); fe0 = 0;
      check("idle_rd_addr", addr0, 32'h400);
      tick(); tick();

      // pending consumed: next start uses pc
      rdata0 = 32'h3333_3333; fe0 = 1; tick();
      check("after_pend_addr", addr0, 32'h404);
      // fe0 stays high one more cycle: a start while in WAIT
      tick(); fe0 = 0;
      check("err_set", 32'(err0), 32'd1);
      check("err_no_done_yet", 32'(done0), 32'd0);
      rdata0 = 32'h4444_4444; tick();
      check("err_done", 32'(done0), 32'd1);
      check("err_instr", instr0, 32'h4444_4444);
      check("err_ipc", ipc0, 32'h404);
      tick();
      check("err_single_done", 32'(done0), 32'd0);
      check("err_no_refetch", 32'(en0), 32'd0);
      check("err_sticky", 32'(err0), 32'd1);

      // reset between imem_en and data return
      rdata0 = 32'h5555_5555; fe0 = 1; tick(); fe0 = 0;
      check("abort_en", 32'(en0), 32'd1);
      rstn = 1'b0; #1;
      check("abort_en_clr", 32'(en0), 32'd0);
      check("abort_err_clr", 32'(err0), 32'd0);
      check("abort_instr", instr0, 32'h0000_0013);
      check("abort_ipc", ipc0, 32'h0);
      check("abort_addr", addr0, 32'h0);
      tick(); rstn = 1'b1;
      tick();
      check("abort_no_done", 32'(done0), 32'd0);
      tick();
      check("abort_no_done2", 32'(done0), 32'd0);
      check("abort_instr_kept", instr0, 32'h0000_0013);

      // PC wrap at top of address space
      rdata0 = 32'h6666_6666; fe0 = 1; rv0 = 1; rp0 = 32'hFFFF_FFFC; tick();
      fe0 = 0; rv0 = 0;
      check("wrap_addr", addr0, 32'hFFFF_FFFC);
      tick(); tick();
      check("wrap_ipc", ipc0, 32'hFFFF_FFFC);
      fe0 = 1; tick(); fe0 = 0;
      check("wrap_next_addr", addr0, 32'h0);
      tick(); tick();

      // latency-4 instance: exact pulse positions
      en_cnt = 0; done_cnt = 0; done_at = 0;
      rdata1 = 32'h7777_7777; fe1 = 1;
      for (int i = 1; i <= 9; i++) begin
         tick();
         fe1 = 0;
         if (en1) begin
            en_cnt++;
            check("l4_en_pos", i, 1);
         end
         if (done1) begin
            done_cnt++;
            done_at = i;
         end
      end
      check("l4_en_cnt", en_cnt, 1);
      check("l4_done_cnt", done_cnt, 1);
      check("l4_done_at", done_at, 6);
      check("l4_instr", instr1, 32'h7777_7777);
      check("l4_ipc", ipc1, 32'h0);
      check("l4_err", 32'(err1), 32'd0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the multicycle core.
- Consumes the one-cycle fetch_enable pulse from the stage-sequencing controller and reads one instruction from a fixed-latency instruction memory.
- Presents the instruction and its PC to decode, and returns a one-cycle fetch_done pulse to the controller.
- Maintains the architectural fetch PC, including branch/jump redirects reported by exec.

Parameters:
- XLEN, 32, width of PC, addresses and instruction word.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- MEM_LATENCY, 1, cycles from the imem_en cycle to imem_rdata valid; legal range 1..7.
- NOP_INSTR, 32'h0000_0013, value of instr after reset.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; one clock, reset is asynchronous and active-low.
- fetch_enable  in  1  one-cycle start pulse from the sequencing controller.
- fetch_done  out  1  one-cycle completion pulse to the sequencing controller.
- redirect_valid  in  1  exec reports a taken branch/jump this cycle.
- redirect_pc  in  XLEN  target PC, qualified by redirect_valid.
- imem_en  out  1  memory read strobe, one cycle per fetch.
- imem_addr  out  XLEN  word-aligned read address, valid while imem_en=1.
- imem_rdata  in  XLEN  read data, valid exactly MEM_LATENCY cycles after the imem_en cycle.
- instr  out  XLEN  last fetched instruction; held until the next fetch completes.
- instr_pc  out  XLEN  address of instr.
- fetch_err  out  1  sticky protocol-violation flag.

Behaviour:
Reset values (asynchronous, all registers):
- state=IDLE, pc=RESET_PC, pending_valid=0, pending_pc=0.
- instr=NOP_INSTR, instr_pc=RESET_PC.
- fetch_done=0, imem_en=0, imem_addr=0, fetch_err=0.
- Reset asserted mid-fetch aborts immediately. No fetch_done is produced for the aborted request, and the data returned later is ignored.

FSM states:
- IDLE: accept a start.
  - On fetch_enable=1: fetch address A is selected by priority:
    1. redirect_pc, if redirect_valid=1 in the same cycle;
    2. else pending_pc, if pending_valid=1;
    3. else pc.
  - Register A into imem_addr and cur_addr, set imem_en=1, clear pending_valid, go to WAIT.
- WAIT: imem_en is high only in the first WAIT cycle.
  - A latency counter (3 bits) loads MEM_LATENCY on entry and decrements each cycle.
  - In the cycle imem_rdata is valid (counter reaches 0), capture instr<=imem_rdata, instr_pc<=cur_addr, pc<=cur_addr+4 (mod 2^XLEN, wraps silently), fetch_done<=1, and return to IDLE.
- fetch_done is registered and high for exactly one cycle.

Timing:
- fetch_enable in cycle t gives imem_en in cycle t+1 and fetch_done/new instr visible in cycle t+2+MEM_LATENCY.
- At MEM_LATENCY=1: 3 cycles. Back-to-back fetch_enable in the fetch_done cycle is legal and starts the next fetch.

Redirects:
- redirect_valid while in WAIT, or in IDLE without fetch_enable, sets pending_valid=1 and pending_pc=redirect_pc. A later redirect overwrites it (last wins).
- The in-flight fetch still completes normally with its original address. Discarding it is the controller's flush responsibility.
- On completion, pc<=cur_addr+4 does not clear pending. Pending always overrides pc at the next start.

Errors:
- fetch_enable while in WAIT is ignored, leaves the current fetch undisturbed, and sets fetch_err=1. Only reset clears fetch_err.
- imem_addr[1:0] is always 0. Redirect targets have bits [1:0] forced to 0.

Decomposition:
- Shared core package holds: XLEN, the NOP_INSTR constant, and the fetch state enum (IDLE, WAIT).
- No sub-module. PC-select and latency counter stay inline.

Test Plan:
- Reset then fetch_enable at cycle 2, L=1, imem_rdata=32'h00500093 → imem_en=1, imem_addr=0 at cycle 3; fetch_done pulse at cycle 5 with instr=32'h00500093, instr_pc=0; next fetch reads address 4.
- fetch_enable together with redirect_valid, redirect_pc=32'h100 → imem_addr=32'h100, instr_pc=32'h100, following fetch at 32'h104.
- redirect_valid with 32'h200 then 32'h300 during WAIT → current fetch completes at its original address; next fetch address 32'h300.
- MEM_LATENCY=4, fetch_enable at t → imem_en only at t+1; fetch_done only at t+6; exactly one pulse.
- fetch_enable re-pulsed during WAIT → fetch_err=1 and stays set; single fetch_done; instr unaffected; rstn low clears fetch_err.
- rstn asserted between imem_en and data return → outputs at reset values immediately, no fetch_done; pc=32'hFFFF_FFFC fetch → next pc wraps to 0.
